// File: rtl/motor_pkg.sv
// -----------------------------------------------------------------------------
// motor_pkg
// Shared constants, per-motor state encoding and the saturating ramp helper
// used by the motor ramp sequencer and its per-motor channels.
// -----------------------------------------------------------------------------
package motor_pkg;

  localparam int NUM_MOTORS = 4;
  localparam int SPEED_W    = 5;
  localparam int SEL_W      = 2;
  // One guard bit above the speed width so that sums never wrap.
  localparam int ARITH_W    = SPEED_W + 1;
  localparam int SPEED_MAX  = (1 << SPEED_W) - 1;

  typedef enum logic [1:0] {
    HOLD  = 2'd0,
    RAMP  = 2'd1,
    BRAKE = 2'd2,
    DWELL = 2'd3
  } motor_state_e;

  // Move cur toward tgt by at most step, landing exactly on tgt when within
  // step. The caller keeps step <= SPEED_MAX, so cur + step fits in ARITH_W.
  function automatic logic [SPEED_W-1:0] ramp_toward(
    input logic [SPEED_W-1:0] cur,
    input logic [SPEED_W-1:0] tgt,
    input logic [ARITH_W-1:0] step
  );
    logic [ARITH_W-1:0] c;
    logic [ARITH_W-1:0] t;
    logic [ARITH_W-1:0] r;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    r = c;
    if (c < t) begin
      r = c + step;
      if (r > t) r = t;
    end else if (c > t) begin
      if ((c - t) <= step) r = t;
      else                 r = c - step;
    end
    return r[SPEED_W-1:0];
  endfunction

endpackage

// File: rtl/motor_ramp_channel.sv
// -----------------------------------------------------------------------------
// motor_ramp_channel
// One motor: target registers, ramp/brake/dwell FSM and dwell counter.
//
// Ports
//   clk, reset     : clock, synchronous active-high reset
//   tick           : one-cycle ramp tick from the shared divider
//   estop          : level emergency stop (zero speeds, drop commands)
//   wr             : command strobe already decoded for this motor
//   cmd_dir        : requested direction
//   cmd_speed      : requested target speed
//   cur_speed      : current ramped speed
//   cur_dir        : current direction
//   at_target      : current speed/direction equal the target
//   state          : FSM state, exposed for debug/checkers
//
// There is no handshake here: wr is a single-cycle strobe that is always
// accepted (unless estop is high) and tick is a single-cycle enable.
// -----------------------------------------------------------------------------
module motor_ramp_channel
  import motor_pkg::*;
#(
  parameter int STEP        = 1,
  parameter int DWELL_TICKS = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               tick,
  input  logic               estop,
  input  logic               wr,
  input  logic               cmd_dir,
  input  logic [SPEED_W-1:0] cmd_speed,
  output logic [SPEED_W-1:0] cur_speed,
  output logic               cur_dir,
  output logic               at_target,
  output motor_state_e       state
);

  localparam int STEP_CLAMP = (STEP > SPEED_MAX) ? SPEED_MAX : STEP;
  localparam logic [ARITH_W-1:0] STEP_V = ARITH_W'(STEP_CLAMP);
  localparam int DWELL_W = (DWELL_TICKS < 1) ? 1 : $clog2(DWELL_TICKS + 1);
  localparam logic [DWELL_W-1:0] DWELL_INIT = DWELL_W'(DWELL_TICKS);

  logic [SPEED_W-1:0] tgt_speed;
  logic               tgt_dir;
  logic [DWELL_W-1:0] dwell;

  logic [SPEED_W-1:0] tgt_speed_nxt;
  logic               tgt_dir_nxt;
  logic [SPEED_W-1:0] cur_speed_nxt;
  logic               cur_dir_nxt;
  motor_state_e       state_nxt;
  logic [DWELL_W-1:0] dwell_nxt;

  logic [SPEED_W-1:0] ramp_speed;
  logic [SPEED_W-1:0] brake_speed;
  motor_state_e       ramp_state;
  logic               dir_match;

  always_ff @(posedge clk) begin
    if (reset) begin
      tgt_speed <= '0;
      tgt_dir   <= 1'b0;
      cur_speed <= '0;
      cur_dir   <= 1'b0;
      state     <= HOLD;
      dwell     <= '0;
    end else begin
      tgt_speed <= tgt_speed_nxt;
      tgt_dir   <= tgt_dir_nxt;
      cur_speed <= cur_speed_nxt;
      cur_dir   <= cur_dir_nxt;
      state     <= state_nxt;
      dwell     <= dwell_nxt;
    end
  end

  always_comb begin
    tgt_speed_nxt = tgt_speed;
    tgt_dir_nxt   = tgt_dir;
    cur_speed_nxt = cur_speed;
    cur_dir_nxt   = cur_dir;
    state_nxt     = state;
    dwell_nxt     = dwell;

    // Step toward the target (used once directions agree, including the
    // tick on which a reversal completes) and step toward zero (braking).
    ramp_speed  = ramp_toward(cur_speed, tgt_speed, STEP_V);
    brake_speed = ramp_toward(cur_speed, '0, STEP_V);
    ramp_state  = (ramp_speed == tgt_speed) ? HOLD : RAMP;
    dir_match   = (cur_dir == tgt_dir);

    if (estop) begin
      cur_speed_nxt = '0;
      tgt_speed_nxt = '0;
      state_nxt     = HOLD;
      dwell_nxt     = '0;
    end else begin
      // The tick sees the registered target; a write in the same cycle only
      // lands in the target registers and takes effect on the next tick.
      if (tick) begin
        if (dir_match) begin
          // Also covers a command restoring the original direction while
          // braking or dwelling: the reversal is simply abandoned.
          cur_speed_nxt = ramp_speed;
          state_nxt     = ramp_state;
          dwell_nxt     = '0;
        end else begin
          unique case (state)
            HOLD, RAMP: begin
              if (cur_speed == '0) begin
                // Already stopped: reverse immediately, no dwell.
                cur_dir_nxt   = tgt_dir;
                cur_speed_nxt = ramp_speed;
                state_nxt     = ramp_state;
              end else begin
                cur_speed_nxt = brake_speed;
                state_nxt     = BRAKE;
              end
            end
            BRAKE: begin
              if (cur_speed == '0) begin
                state_nxt = DWELL;
                dwell_nxt = DWELL_INIT;
              end else begin
                cur_speed_nxt = brake_speed;
              end
            end
            DWELL: begin
              if (dwell == '0) begin
                cur_dir_nxt   = tgt_dir;
                cur_speed_nxt = ramp_speed;
                state_nxt     = ramp_state;
              end else begin
                dwell_nxt = dwell - 1'b1;
              end
            end
            default: state_nxt = HOLD;
          endcase
        end
      end
      if (wr) begin
        tgt_speed_nxt = cmd_speed;
        tgt_dir_nxt   = cmd_dir;
      end
    end
  end

  assign at_target = (cur_speed == tgt_speed) && dir_match;

endmodule

// File: rtl/motor_ramp_sequencer.sv
// -----------------------------------------------------------------------------
// motor_ramp_sequencer
// Four-motor speed ramp sequencer. A shared divider produces ramp ticks; each
// motor channel ramps its current speed toward the commanded target, braking
// and dwelling at zero before a direction reversal. A round-robin output stage
// presents one motor per cycle to the downstream motor controller.
//
// Ports
//   clk, reset   : clock, synchronous active-high reset
//   cmd_wr       : single-cycle command strobe
//   cmd_motor    : target motor index for the command
//   cmd_dir      : requested direction
//   cmd_speed    : requested target speed, 0..31
//   estop        : level emergency stop
//   motor_select : round-robin motor index
//   speed        : current speed of motor_select
//   direction    : current direction of motor_select
//   at_target    : per motor, current speed/direction equal the target
//   motor_state  : per-motor FSM state, 2 bits per motor, debug only
//
// Commands are fire-and-forget strobes (no ready); the output triple is
// registered together every cycle, so motor_select/speed/direction always
// describe the same motor at the same instant.
// -----------------------------------------------------------------------------
module motor_ramp_sequencer
  import motor_pkg::*;
#(
  parameter int RAMP_DIV    = 25000,
  parameter int STEP        = 1,
  parameter int DWELL_TICKS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_wr,
  input  logic [SEL_W-1:0]        cmd_motor,
  input  logic                    cmd_dir,
  input  logic [SPEED_W-1:0]      cmd_speed,
  input  logic                    estop,
  output logic [SEL_W-1:0]        motor_select,
  output logic [SPEED_W-1:0]      speed,
  output logic                    direction,
  output logic [NUM_MOTORS-1:0]   at_target,
  output logic [2*NUM_MOTORS-1:0] motor_state
);

  localparam int CNT_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RAMP_DIV - 1);

  logic [CNT_W-1:0]   tick_count;
  logic               tick;
  logic [SEL_W-1:0]   pointer;

  logic [SPEED_W-1:0] cur_speed_arr [NUM_MOTORS];
  logic [NUM_MOTORS-1:0] cur_dir_vec;
  motor_state_e       channel_state [NUM_MOTORS];

  // Free-running ramp divider; tick is high for the one cycle the counter
  // sits at its last value.
  assign tick = (tick_count == CNT_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      tick_count <= '0;
    end else if (tick) begin
      tick_count <= '0;
    end else begin
      tick_count <= tick_count + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_MOTORS; i++) begin : g_ch
    motor_ramp_channel #(
      .STEP        (STEP),
      .DWELL_TICKS (DWELL_TICKS)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick),
      .estop     (estop),
      .wr        (cmd_wr && (cmd_motor == SEL_W'(i))),
      .cmd_dir   (cmd_dir),
      .cmd_speed (cmd_speed),
      .cur_speed (cur_speed_arr[i]),
      .cur_dir   (cur_dir_vec[i]),
      .at_target (at_target[i]),
      .state     (channel_state[i])
    );
    assign motor_state[2*i +: 2] = channel_state[i];
  end

  // Round-robin output stage. NUM_MOTORS is a power of two, so the pointer
  // wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      pointer      <= '0;
      motor_select <= '0;
      speed        <= '0;
      direction    <= 1'b0;
    end else begin
      motor_select <= pointer;
      speed        <= cur_speed_arr[pointer];
      direction    <= cur_dir_vec[pointer];
      pointer      <= pointer + 1'b1;
    end
  end

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// -----------------------------------------------------------------------------
// tb_motor_ramp_sequencer
// Directed scenarios followed by random commands/estops/resets. Every edge the
// driver advances a behavioural model and queues the outputs expected after
// that edge; a monitor pops and compares one entry per edge.
// -----------------------------------------------------------------------------
module tb_motor_ramp_sequencer;

  localparam int RAMP_DIV    = 4;
  localparam int STEP        = 1;
  localparam int DWELL_TICKS = 2;
  localparam int NM          = 4;
  localparam int EXP_W       = 12;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       cmd_wr;
  logic [1:0] cmd_motor;
  logic       cmd_dir;
  logic [4:0] cmd_speed;
  logic       estop;
  logic [1:0] motor_select;
  logic [4:0] speed;
  logic       direction;
  logic [3:0] at_target;
  logic [7:0] motor_state;

  motor_ramp_sequencer #(
    .RAMP_DIV    (RAMP_DIV),
    .STEP        (STEP),
    .DWELL_TICKS (DWELL_TICKS)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_wr       (cmd_wr),
    .cmd_motor    (cmd_motor),
    .cmd_dir      (cmd_dir),
    .cmd_speed    (cmd_speed),
    .estop        (estop),
    .motor_select (motor_select),
    .speed        (speed),
    .direction    (direction),
    .at_target    (at_target),
    .motor_state  (motor_state)
  );

  // Reference model: plain integers per motor. dwell = -1 means "not
  // waiting at zero"; braking marks a motor slowing down for a reversal.
  int m_cnt;
  int m_ptr;
  int m_cur   [NM];
  int m_tgt   [NM];
  int m_dwell [NM];
  bit m_cdir  [NM];
  bit m_tdir  [NM];
  bit m_braking [NM];

  logic [EXP_W-1:0] exp_q[$];
  int checks = 0;
  int fails  = 0;

  function automatic int approach(int cur, int tgt);
    if (cur < tgt) return (cur + STEP > tgt) ? tgt : cur + STEP;
    if (cur > tgt) return (cur - tgt <= STEP) ? tgt : cur - STEP;
    return cur;
  endfunction

  task automatic model_motor_tick(int i);
    if (m_cdir[i] == m_tdir[i]) begin
      m_cur[i]     = approach(m_cur[i], m_tgt[i]);
      m_braking[i] = 1'b0;
      m_dwell[i]   = -1;
    end else if (m_dwell[i] > 0) begin
      m_dwell[i] = m_dwell[i] - 1;
    end else if (m_dwell[i] == 0 || (!m_braking[i] && m_cur[i] == 0)) begin
      m_cdir[i]    = m_tdir[i];
      m_cur[i]     = approach(m_cur[i], m_tgt[i]);
      m_dwell[i]   = -1;
      m_braking[i] = 1'b0;
    end else if (m_cur[i] == 0) begin
      m_braking[i] = 1'b0;
      m_dwell[i]   = DWELL_TICKS;
    end else begin
      m_cur[i]     = (m_cur[i] > STEP) ? m_cur[i] - STEP : 0;
      m_braking[i] = 1'b1;
    end
  endtask

  task automatic model_edge(bit r, bit wr, int m, bit d, int s, bit e);
    int sel;
    int spd;
    bit dir;
    bit tk;
    logic [3:0] at;
    sel = 0;
    spd = 0;
    dir = 1'b0;
    if (r) begin
      m_cnt = 0;
      m_ptr = 0;
      for (int i = 0; i < NM; i++) begin
        m_cur[i] = 0; m_tgt[i] = 0; m_cdir[i] = 0; m_tdir[i] = 0;
        m_dwell[i] = -1; m_braking[i] = 0;
      end
    end else begin
      tk    = (m_cnt == RAMP_DIV - 1);
      m_cnt = tk ? 0 : m_cnt + 1;
      sel   = m_ptr;
      spd   = m_cur[m_ptr];
      dir   = m_cdir[m_ptr];
      m_ptr = (m_ptr + 1) % NM;
      if (e) begin
        for (int i = 0; i < NM; i++) begin
          m_cur[i] = 0; m_tgt[i] = 0; m_dwell[i] = -1; m_braking[i] = 0;
        end
      end else begin
        if (tk) for (int i = 0; i < NM; i++) model_motor_tick(i);
        if (wr) begin
          m_tgt[m]  = s;
          m_tdir[m] = d;
        end
      end
    end
    for (int i = 0; i < NM; i++)
      at[i] = (m_cur[i] == m_tgt[i]) && (m_cdir[i] == m_tdir[i]);
    exp_q.push_back({sel[1:0], spd[4:0], dir, at});
  endtask

  // Driver tasks: inputs change on the falling edge, model steps in lockstep.
  task automatic drive(bit r, bit wr, int m, bit d, int s, bit e);
    @(negedge clk);
    reset     = r;
    cmd_wr    = wr;
    cmd_motor = m[1:0];
    cmd_dir   = d;
    cmd_speed = s[4:0];
    estop     = e;
    model_edge(r, wr, m, d, s, e);
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) drive(0, 0, 0, 0, 0, 0);
  endtask

  task automatic cmd(int m, bit d, int s);
    drive(0, 1, m, d, s, 0);
  endtask

  // Idle until the next driven edge is a ramp-tick edge.
  task automatic to_tick_edge();
    for (int k = 0; k < RAMP_DIV && m_cnt != RAMP_DIV - 1; k++) idle(1);
  endtask

  task automatic wait_speed(int m, int v);
    for (int k = 0; k < 400 && m_cur[m] != v; k++) idle(1);
  endtask

  // Monitor / scoreboard
  always @(posedge clk) begin
    logic [EXP_W-1:0] e;
    logic [EXP_W-1:0] got;
    #1;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {motor_select, speed, direction, at_target};
      checks++;
      if (got !== e) begin
        fails++;
        $display("FAIL outputs t=%0t got sel=%0d spd=%0d dir=%0d at=%b exp sel=%0d spd=%0d dir=%0d at=%b",
                 $time, got[11:10], got[9:5], got[4], got[3:0],
                 e[11:10], e[9:5], e[4], e[3:0]);
      end
    end
  end

  initial begin
    reset = 1'b1; cmd_wr = 1'b0; cmd_motor = '0; cmd_dir = 1'b0;
    cmd_speed = '0; estop = 1'b0;

    // Reset state, then round-robin select.
    for (int k = 0; k < 3; k++) drive(1, 0, 0, 0, 0, 0);
    idle(8);

    // Motor 1 ramps 0 -> 10 forward from rest.
    cmd(1, 1, 10);
    idle(RAMP_DIV * 12);

    // Motor 2: reach 5 forward, then reverse to 3 with brake and dwell.
    cmd(2, 1, 5);
    idle(RAMP_DIV * 8);
    cmd(2, 0, 3);
    idle(RAMP_DIV * 16);

    // Reversal abandoned while braking, then while dwelling.
    cmd(2, 1, 9);
    idle(RAMP_DIV * 2);
    cmd(2, 0, 9);
    idle(RAMP_DIV * 10);
    cmd(2, 1, 4);
    wait_speed(2, 0);
    idle(RAMP_DIV * 2);
    cmd(2, 0, 4);
    idle(RAMP_DIV * 8);

    // Motor 3: target lowered on the very edge of a tick.
    cmd(3, 1, 20);
    wait_speed(3, 12);
    to_tick_edge();
    cmd(3, 1, 8);
    idle(RAMP_DIV * 10);

    // Motor 0 ramping, estop together with a command (command dropped).
    cmd(0, 0, 20);
    wait_speed(0, 7);
    drive(0, 1, 0, 0, 31, 1);
    idle(RAMP_DIV * 4);

    // Reset in the middle of a ramp.
    cmd(1, 0, 30);
    idle(20);
    drive(1, 1, 1, 1, 17, 1);
    idle(RAMP_DIV * 3);

    // Random phase.
    for (int c = 0; c < 3000; c++) begin
      bit r;
      bit e;
      bit w;
      r = ($urandom_range(0, 511) == 0);
      e = ($urandom_range(0, 63) == 0);
      w = ($urandom_range(0, 7) == 0);
      drive(r, w, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
            $urandom_range(0, 31), e);
    end
    idle(4);

    // Every queued expectation must have been consumed.
    @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL queue_drain got %0d pending entries, required 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
